// File: rtl/date_time_set_ctrl.sv
// Field-by-field date/time setting controller with shadow registers and a single commit strobe.
// Optional LEAP_YEAR_EN: February gets 29 days when the shadow year is a multiple of four.
module date_time_set_ctrl #(
    parameter int unsigned BLINK_DIV = 25_000_000,
    parameter int unsigned TIMEOUT   = 1_500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [5:0] cur_min,
    input  logic [4:0] cur_hour,
    input  logic [4:0] cur_day,
    input  logic [3:0] cur_mon,
    input  logic [6:0] cur_year,
    output logic       set_active,
    output logic [2:0] field_sel,
    output logic       load,
    output logic [5:0] set_min,
    output logic [4:0] set_hour,
    output logic [4:0] set_day,
    output logic [3:0] set_mon,
    output logic [6:0] set_year,
    output logic       blink
);

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_YEAR = 3'd1,
        SET_MON  = 3'd2,
        SET_DAY  = 3'd3,
        SET_HOUR = 3'd4,
        SET_MIN  = 3'd5,
        COMMIT   = 3'd6
    } state_t;

    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int BLK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    function automatic logic [4:0] days_in_month(input logic [3:0] mon, input logic [4:0] feb_days);
        case (mon)
            4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
            4'd2:                    days_in_month = feb_days;
            default:                 days_in_month = 5'd31;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic             btn_mode_q, btn_inc_q;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             blink_q, blink_d;
    logic             load_q, load_d;
    logic             set_active_q, set_active_d;
    logic [5:0]       set_min_q, set_min_d;
    logic [4:0]       set_hour_q, set_hour_d;
    logic [4:0]       set_day_q, set_day_d;
    logic [3:0]       set_mon_q, set_mon_d;
    logic [6:0]       set_year_q, set_year_d;

    logic       mode_edge, inc_edge;
    logic       in_set, next_in_set;
    logic [4:0] feb_days, dim;

`ifdef LEAP_YEAR_EN
    assign feb_days = (set_year_q[1:0] == 2'b00) ? 5'd29 : 5'd28;
`else
    assign feb_days = 5'd28;
`endif
    assign dim = days_in_month(set_mon_q, feb_days);

    // A simultaneous mode edge swallows the inc edge.
    assign mode_edge = btn_mode & ~btn_mode_q;
    assign inc_edge  = btn_inc & ~btn_inc_q & ~mode_edge;
    assign in_set    = (state_q inside {SET_YEAR, SET_MON, SET_DAY, SET_HOUR, SET_MIN});

    always_comb begin
        state_d    = state_q;
        set_min_d  = set_min_q;
        set_hour_d = set_hour_q;
        set_day_d  = set_day_q;
        set_mon_d  = set_mon_q;
        set_year_d = set_year_q;
        case (state_q)
            RUN: begin
                if (mode_edge) begin
                    state_d    = SET_YEAR;
                    set_min_d  = cur_min;
                    set_hour_d = cur_hour;
                    set_day_d  = cur_day;
                    set_mon_d  = cur_mon;
                    set_year_d = cur_year;
                end
            end
            COMMIT: state_d = RUN;
            default: begin
                if (mode_edge) begin
                    state_d = state_t'(state_q + 3'd1);
                    if ((state_q == SET_MON || state_q == SET_MIN) && set_day_q > dim)
                        set_day_d = dim;
                end else if (inc_edge) begin
                    case (state_q)
                        SET_YEAR: set_year_d = (set_year_q >= 7'd99) ? 7'd0 : set_year_q + 7'd1;
                        SET_MON:  set_mon_d  = (set_mon_q >= 4'd12) ? 4'd1 : set_mon_q + 4'd1;
                        SET_DAY:  set_day_d  = (set_day_q >= dim) ? 5'd1 : set_day_q + 5'd1;
                        SET_HOUR: set_hour_d = (set_hour_q >= 5'd23) ? 5'd0 : set_hour_q + 5'd1;
                        default:  set_min_d  = (set_min_q >= 6'd59) ? 6'd0 : set_min_q + 6'd1;
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    state_d = RUN;
                end
            end
        endcase

        next_in_set  = (state_d inside {SET_YEAR, SET_MON, SET_DAY, SET_HOUR, SET_MIN});
        load_d       = (state_d == COMMIT);
        set_active_d = next_in_set;
        tmo_d        = (in_set && !mode_edge && !inc_edge && state_d == state_q)
                       ? tmo_q + TMO_W'(1) : '0;

        // Blink phase restarts whenever an edit session begins or ends.
        blk_cnt_d = '0;
        blink_d   = 1'b0;
        if (in_set && next_in_set) begin
            if (blk_cnt_q == BLK_LAST) begin
                blink_d = ~blink_q;
            end else begin
                blk_cnt_d = blk_cnt_q + BLK_W'(1);
                blink_d   = blink_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            btn_mode_q   <= 1'b0;
            btn_inc_q    <= 1'b0;
            tmo_q        <= '0;
            blk_cnt_q    <= '0;
            blink_q      <= 1'b0;
            load_q       <= 1'b0;
            set_active_q <= 1'b0;
            set_min_q    <= 6'd0;
            set_hour_q   <= 5'd0;
            set_day_q    <= 5'd1;
            set_mon_q    <= 4'd1;
            set_year_q   <= 7'd0;
        end else begin
            state_q      <= state_d;
            btn_mode_q   <= btn_mode;
            btn_inc_q    <= btn_inc;
            tmo_q        <= tmo_d;
            blk_cnt_q    <= blk_cnt_d;
            blink_q      <= blink_d;
            load_q       <= load_d;
            set_active_q <= set_active_d;
            set_min_q    <= set_min_d;
            set_hour_q   <= set_hour_d;
            set_day_q    <= set_day_d;
            set_mon_q    <= set_mon_d;
            set_year_q   <= set_year_d;
        end
    end

    assign set_active = set_active_q;
    assign field_sel  = state_q;
    assign load       = load_q;
    assign blink      = blink_q;
    assign set_min    = set_min_q;
    assign set_hour   = set_hour_q;
    assign set_day    = set_day_q;
    assign set_mon    = set_mon_q;
    assign set_year   = set_year_q;

endmodule

// File: doc/date_time_set_ctrl.md
# date_time_set_ctrl

User-setting controller for the century clock's time/date counter chain. It watches two synchronized push-button levels and walks a field-select state machine: year, month, day, hour, minute. It edits shadow copies of the counter values and issues a single-cycle load strobe so the counters take all five fields at once. Edits validate day against days-in-month, and an inactivity timeout aborts editing without loading.

## Interface
- BLINK_DIV, 25_000_000, clk cycles per half-period of the blink output
- TIMEOUT, 1_500_000_000, clk cycles without a button edge before an edit session aborts
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- btn_mode  in  1  mode button, already synchronized/debounced, level
- btn_inc  in  1  increment button, already synchronized/debounced, level
- cur_min  in  6  live minute value, binary 0..59
- cur_hour  in  5  live hour value, binary 0..23
- cur_day  in  5  live day value, binary 1..31
- cur_mon  in  4  live month value, binary 1..12
- cur_year  in  7  live year-of-century value, binary 0..99
- set_active  out  1  high in any edit state
- field_sel  out  3  current state code (see Operation)
- load  out  1  one-cycle commit strobe to the counter chain
- set_min / set_hour / set_day / set_mon / set_year  out  6/5/5/4/7  shadow values, valid while load=1
- blink  out  1  toggles every BLINK_DIV cycles while set_active, else 0

## Operation
- Edges: mode_edge = btn_mode & ~btn_mode_q and inc_edge = btn_inc & ~btn_inc_q, where the _q versions are registered copies of the button inputs.
- If both edges occur in the same cycle, mode wins and the inc edge is dropped.
- States and field_sel codes: RUN=0, SET_YEAR=1, SET_MON=2, SET_DAY=3, SET_HOUR=4, SET_MIN=5, COMMIT=6.
- RUN → SET_YEAR on mode_edge. On that transition all shadows capture cur_* in the same cycle.
- SET_YEAR → SET_MON → SET_DAY → SET_HOUR → SET_MIN, each step on mode_edge.
- SET_MIN → COMMIT on mode_edge.
- COMMIT lasts exactly 1 cycle with load=1, then returns to RUN unconditionally.
- inc_edge increments only the selected shadow field, with these wraps:
  - year: 99→0
  - month: 12→1
  - day: dim→1
  - hour: 23→0
  - minute: 59→0
- dim is the days in the selected month: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; 28 for month 2, or 29 when leap (see Configuration).
- Day clamp: on the SET_MON→SET_DAY transition and on the SET_MIN→COMMIT transition, if set_day > dim then set_day <= dim.
- Timeout counter:
  - clears on any mode_edge or inc_edge, and while in RUN;
  - in any SET_* state, reaching TIMEOUT-1 forces RUN with no load, and the shadows are left as-is.
- Blink counter:
  - runs only while set_active; blink toggles when the counter reaches BLINK_DIV-1;
  - counter and blink clear on the RUN→SET_YEAR transition and whenever in RUN.
- Reset (asynchronous, any state including mid-edit):
  - state RUN, load 0, set_active 0, field_sel 0, blink 0;
  - set_min 0, set_hour 0, set_day 1, set_mon 1, set_year 0;
  - timeout and blink counters 0, btn_*_q 0.
- Arithmetic is unsigned at field width. Comparisons use binary values.

## Timing
- A button sampled high in cycle N, with the previous sample low, changes state/shadow registers at the clock edge ending cycle N. The effect is visible in cycle N+1.
- From mode_edge in SET_MIN: load=1 in cycle N+1 only, and field_sel=6 in that cycle.
- set_* are stable during the load cycle and stay held until the next capture.
- set_active and field_sel are registered outputs (state decode is registered, no combinational path from the buttons).
- A held button produces exactly one edge, with no auto-repeat.

## Configuration
- LEAP_YEAR_EN defined: dim for month 2 is 29 when set_year[1:0]==0 (the century is fixed at 2000, so 00 is a leap year), otherwise 28.
- LEAP_YEAR_EN undefined: dim for month 2 is always 28, and leap logic is absent from the netlist.

## Test plan
- Reset mid-edit: enter SET_DAY, assert rst_n=0 → field_sel=0, load=0, set_day=1, set_mon=1 immediately, without waiting for a clk edge.
- Full pass: cur = 2024-03-01 12:34, sequence mode, inc×2 (year), mode×4, mode → load pulses once with set_year=26, set_mon=3, set_day=1, set_hour=12, set_min=34.
- Day clamp: capture day 31 month 1, inc month to 2, year 23 → entering SET_DAY gives set_day=28. With LEAP_YEAR_EN and year 24 → 29.
- Wrap: in SET_MIN from 59, one inc → 0. In SET_MON from 12 → 1. In SET_DAY at month 4 from 30 → 1.
- Simultaneous mode and inc rising edges in SET_HOUR → state SET_MIN, set_hour unchanged.
- Timeout with TIMEOUT=16: enter SET_YEAR, no buttons → RUN after 16 cycles, load never asserted, blink 0 in RUN.
